// File: rtl/dmem_arbiter.sv
// Two-requester round-robin arbiter and access sequencer in front of data_mem.
// Optional WAIT-state timeout (err pulse with done) is enabled by `define DMEM_ARB_TIMEOUT_EN.
module dmem_arbiter #(
  parameter int unsigned STALL_SETTLE   = 1,
  parameter int unsigned TIMEOUT_CYCLES = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        r0_req,
  input  logic [31:0] r0_addr,
  input  logic        r0_write,
  input  logic [31:0] r0_wdata,
  input  logic [3:0]  r0_sign_mask,
  output logic        r0_gnt,
  output logic        r0_done,
  input  logic        r1_req,
  input  logic [31:0] r1_addr,
  input  logic        r1_write,
  input  logic [31:0] r1_wdata,
  input  logic [3:0]  r1_sign_mask,
  output logic        r1_gnt,
  output logic        r1_done,
  output logic [31:0] rdata,
  output logic        err,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_write_data,
  output logic        mem_memwrite,
  output logic        mem_memread,
  output logic [3:0]  mem_sign_mask,
  input  logic [31:0] mem_read_data,
  input  logic        mem_clk_stall
);

  localparam int unsigned CNT_MAX = (TIMEOUT_CYCLES > STALL_SETTLE) ? TIMEOUT_CYCLES : STALL_SETTLE;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_owner;
  logic             r_last_owner;
  logic             r_write;
  logic [31:0]      r_mem_addr;
  logic [31:0]      r_mem_wdata;
  logic [3:0]       r_mem_mask;
  logic             r_memread;
  logic             r_memwrite;
  logic [31:0]      r_rdata;
  logic             r_gnt0;
  logic             r_gnt1;
  logic             r_done0;
  logic             r_done1;

  logic w_any_req;
  logic w_pick1;
  logic w_settled;

  // On a tie the requester that did not own the previous access wins.
  assign w_any_req = r0_req | r1_req;
  assign w_pick1   = r1_req & (~r0_req | ~r_last_owner);
  assign w_settled = (r_cnt >= CNT_W'(STALL_SETTLE)) & ~mem_clk_stall;

`ifdef DMEM_ARB_TIMEOUT_EN
  logic r_err;
  logic w_timeout;
  assign w_timeout = mem_clk_stall & (r_cnt >= CNT_W'(TIMEOUT_CYCLES - 1));
  assign err       = r_err;
`else
  assign err = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_owner      <= 1'b0;
      r_last_owner <= 1'b1;
      r_write      <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_mem_mask   <= '0;
      r_memread    <= 1'b0;
      r_memwrite   <= 1'b0;
      r_rdata      <= '0;
      r_gnt0       <= 1'b0;
      r_gnt1       <= 1'b0;
      r_done0      <= 1'b0;
      r_done1      <= 1'b0;
`ifdef DMEM_ARB_TIMEOUT_EN
      r_err        <= 1'b0;
`endif
    end else begin
      r_gnt0     <= 1'b0;
      r_gnt1     <= 1'b0;
      r_done0    <= 1'b0;
      r_done1    <= 1'b0;
      r_memread  <= 1'b0;
      r_memwrite <= 1'b0;
`ifdef DMEM_ARB_TIMEOUT_EN
      r_err      <= 1'b0;
`endif
      case (r_state)
        S_IDLE: begin
          if (w_any_req) begin
            r_owner     <= w_pick1;
            r_gnt0      <= ~w_pick1;
            r_gnt1      <= w_pick1;
            r_mem_addr  <= w_pick1 ? r1_addr      : r0_addr;
            r_mem_wdata <= w_pick1 ? r1_wdata     : r0_wdata;
            r_mem_mask  <= w_pick1 ? r1_sign_mask : r0_sign_mask;
            r_write     <= w_pick1 ? r1_write     : r0_write;
            r_state     <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          r_memread  <= ~r_write;
          r_memwrite <= r_write;
          r_cnt      <= '0;
          r_state    <= S_WAIT;
        end
        S_WAIT: begin
          if (r_cnt != {CNT_W{1'b1}}) begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
          if (w_settled) begin
            if (!r_write) begin
              r_rdata <= mem_read_data;
            end
            r_done0 <= ~r_owner;
            r_done1 <= r_owner;
            r_state <= S_DONE;
          end
`ifdef DMEM_ARB_TIMEOUT_EN
          else if (w_timeout) begin
            if (!r_write) begin
              r_rdata <= 32'hDEADBEEF;
            end
            r_done0 <= ~r_owner;
            r_done1 <= r_owner;
            r_err   <= 1'b1;
            r_state <= S_DONE;
          end
`endif
        end
        S_DONE: begin
          r_last_owner <= r_owner;
          r_state      <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign r0_gnt         = r_gnt0;
  assign r1_gnt         = r_gnt1;
  assign r0_done        = r_done0;
  assign r1_done        = r_done1;
  assign rdata          = r_rdata;
  assign mem_addr       = r_mem_addr;
  assign mem_write_data = r_mem_wdata;
  assign mem_memwrite   = r_memwrite;
  assign mem_memread    = r_memread;
  assign mem_sign_mask  = r_mem_mask;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed self-checking bench for dmem_arbiter with a simple stalling memory model.
// Timeout scenario runs only when DMEM_ARB_TIMEOUT_EN is defined.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        r0_req, r0_write, r1_req, r1_write;
  logic [31:0] r0_addr, r0_wdata, r1_addr, r1_wdata;
  logic [3:0]  r0_sign_mask, r1_sign_mask;
  logic        r0_gnt, r0_done, r1_gnt, r1_done;
  logic [31:0] rdata;
  logic        err;
  logic [31:0] mem_addr, mem_write_data, mem_read_data;
  logic        mem_memwrite, mem_memread, mem_clk_stall;
  logic [3:0]  mem_sign_mask;

  int tests = 0;
  int fails = 0;

  int   stall_len   = 0;
  int   stall_rem   = 0;
  logic model_stall = 1'b0;
  logic stall_stuck = 1'b0;
  int   n_rd = 0, n_wr = 0, n_both_gnt = 0, n_both_done = 0;
  int   gnt_log[$];

  dmem_arbiter dut (
    .clk(clk), .rst(rst),
    .r0_req(r0_req), .r0_addr(r0_addr), .r0_write(r0_write), .r0_wdata(r0_wdata),
    .r0_sign_mask(r0_sign_mask), .r0_gnt(r0_gnt), .r0_done(r0_done),
    .r1_req(r1_req), .r1_addr(r1_addr), .r1_write(r1_write), .r1_wdata(r1_wdata),
    .r1_sign_mask(r1_sign_mask), .r1_gnt(r1_gnt), .r1_done(r1_done),
    .rdata(rdata), .err(err),
    .mem_addr(mem_addr), .mem_write_data(mem_write_data), .mem_memwrite(mem_memwrite),
    .mem_memread(mem_memread), .mem_sign_mask(mem_sign_mask),
    .mem_read_data(mem_read_data), .mem_clk_stall(mem_clk_stall)
  );

  always #5 clk = ~clk;

  // Memory stall model: stall rises the cycle after a strobe and lasts stall_len cycles.
  assign mem_clk_stall = model_stall | stall_stuck;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      model_stall <= 1'b0;
      stall_rem   <= 0;
    end else if ((mem_memread || mem_memwrite) && stall_len > 0) begin
      model_stall <= 1'b1;
      stall_rem   <= stall_len - 1;
    end else if (stall_rem > 0) begin
      stall_rem <= stall_rem - 1;
    end else begin
      model_stall <= 1'b0;
    end
  end

  always @(negedge clk) begin
    if (mem_memread)          n_rd++;
    if (mem_memwrite)         n_wr++;
    if (r0_gnt && r1_gnt)     n_both_gnt++;
    if (r0_done && r1_done)   n_both_done++;
    if (r0_gnt)               gnt_log.push_back(0);
    if (r1_gnt)               gnt_log.push_back(1);
  end

  // One access from requester rq; inputs are scrambled after grant to prove latching.
  task automatic do_access(input int rq, input logic wr, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [3:0] mask,
                           output int gnt_cyc, output int done_cyc, output int hold_viol,
                           output logic err_at_done);
    gnt_cyc = -1; done_cyc = -1; hold_viol = 0; err_at_done = 1'b0;
    @(negedge clk);
    if (rq == 0) begin
      r0_req = 1; r0_write = wr; r0_addr = addr; r0_wdata = wdata; r0_sign_mask = mask;
    end else begin
      r1_req = 1; r1_write = wr; r1_addr = addr; r1_wdata = wdata; r1_sign_mask = mask;
    end
    for (int c = 0; c < 200 && done_cyc < 0; c++) begin
      @(negedge clk);
      if (gnt_cyc < 0 && ((rq == 0) ? r0_gnt : r1_gnt)) begin
        gnt_cyc = c;
        r0_req = 0; r1_req = 0;
        r0_addr = ~addr; r0_wdata = ~wdata; r0_sign_mask = ~mask; r0_write = ~wr;
        r1_addr = ~addr; r1_wdata = ~wdata; r1_sign_mask = ~mask; r1_write = ~wr;
      end
      if (gnt_cyc >= 0) begin
        if (mem_addr !== addr || mem_sign_mask !== mask || (wr && mem_write_data !== wdata))
          hold_viol++;
      end
      if ((rq == 0) ? r0_done : r1_done) begin
        done_cyc    = c;
        err_at_done = err;
      end
    end
    r0_req = 0; r1_req = 0;
  endtask

  task automatic test_reset();
    tests++; if (r0_gnt !== 0 || r1_gnt !== 0) begin fails++; $display("FAIL reset_gnt: got %b%b want 00", r1_gnt, r0_gnt); end
    tests++; if (r0_done !== 0 || r1_done !== 0) begin fails++; $display("FAIL reset_done: got %b%b want 00", r1_done, r0_done); end
    tests++; if (mem_memread !== 0 || mem_memwrite !== 0) begin fails++; $display("FAIL reset_strobe: got rd=%b wr=%b want 0", mem_memread, mem_memwrite); end
    tests++; if (mem_addr !== 0 || mem_write_data !== 0 || mem_sign_mask !== 0) begin fails++; $display("FAIL reset_mem_bus: addr=%h wd=%h mask=%h want 0", mem_addr, mem_write_data, mem_sign_mask); end
    tests++; if (rdata !== 0 || err !== 0) begin fails++; $display("FAIL reset_rdata_err: rdata=%h err=%b want 0", rdata, err); end
  endtask

  task automatic test_r0_load();
    int g, d, h, rd0, wr0; logic e;
    stall_len = 3; mem_read_data = 32'h00001748;
    rd0 = n_rd; wr0 = n_wr;
    do_access(0, 1'b0, 32'h1001, 32'h0, 4'b0010, g, d, h, e);
    @(negedge clk);
    tests++; if (g !== 0) begin fails++; $display("FAIL r0_load_gnt_cycle: got %0d want 0", g); end
    tests++; if (d !== 6) begin fails++; $display("FAIL r0_load_done_cycle: got %0d want 6", d); end
    tests++; if (n_rd - rd0 !== 1) begin fails++; $display("FAIL r0_load_memread_pulses: got %0d want 1", n_rd - rd0); end
    tests++; if (n_wr - wr0 !== 0) begin fails++; $display("FAIL r0_load_memwrite_pulses: got %0d want 0", n_wr - wr0); end
    tests++; if (h !== 0) begin fails++; $display("FAIL r0_load_addr_hold: %0d unstable cycles want 0", h); end
    tests++; if (rdata !== 32'h00001748) begin fails++; $display("FAIL r0_load_rdata: got %h want 00001748", rdata); end
    tests++; if (e !== 1'b0) begin fails++; $display("FAIL r0_load_err: got %b want 0", e); end
  endtask

  task automatic test_r1_store();
    int g, d, h, rd0, wr0; logic e;
    stall_len = 2; mem_read_data = 32'hBAD0BAD0;
    rd0 = n_rd; wr0 = n_wr;
    do_access(1, 1'b1, 32'h2000, 32'hCAFEF00D, 4'b1111, g, d, h, e);
    @(negedge clk);
    tests++; if (d !== 5) begin fails++; $display("FAIL r1_store_done_cycle: got %0d want 5", d); end
    tests++; if (n_wr - wr0 !== 1) begin fails++; $display("FAIL r1_store_memwrite_pulses: got %0d want 1", n_wr - wr0); end
    tests++; if (n_rd - rd0 !== 0) begin fails++; $display("FAIL r1_store_memread_pulses: got %0d want 0", n_rd - rd0); end
    tests++; if (h !== 0) begin fails++; $display("FAIL r1_store_data_hold: %0d unstable cycles want 0", h); end
    tests++; if (rdata !== 32'h00001748) begin fails++; $display("FAIL r1_store_rdata_kept: got %h want 00001748", rdata); end
  endtask

  task automatic test_round_robin();
    int base, bg0, bd0, nd;
    stall_len = 1; mem_read_data = 32'h11112222;
    base = gnt_log.size(); bg0 = n_both_gnt; bd0 = n_both_done; nd = 0;
    @(negedge clk);
    r0_req = 1; r0_write = 0; r0_addr = 32'h3000; r0_sign_mask = 4'b1111;
    r1_req = 1; r1_write = 0; r1_addr = 32'h4000; r1_sign_mask = 4'b1111;
    for (int c = 0; c < 400 && nd < 4; c++) begin
      @(negedge clk);
      if (r0_done || r1_done) nd++;
    end
    r0_req = 0; r1_req = 0;
    repeat (4) @(negedge clk);
    tests++; if (nd !== 4) begin fails++; $display("FAIL rr_done_count: got %0d want 4", nd); end
    tests++; if (gnt_log.size() - base !== 4) begin fails++; $display("FAIL rr_gnt_count: got %0d want 4", gnt_log.size() - base); end
    for (int i = 0; i < 4; i++) begin
      if (base + i < gnt_log.size()) begin
        tests++;
        if (gnt_log[base + i] !== (i % 2)) begin
          fails++; $display("FAIL rr_order[%0d]: got %0d want %0d", i, gnt_log[base + i], i % 2);
        end
      end
    end
    tests++; if (n_both_gnt - bg0 !== 0 || n_both_done - bd0 !== 0) begin fails++; $display("FAIL rr_exclusive: both_gnt=%0d both_done=%0d want 0", n_both_gnt - bg0, n_both_done - bd0); end
  endtask

  task automatic test_zero_stall();
    int g, d, h; logic e;
    stall_len = 0; mem_read_data = 32'h5A5A0001;
    do_access(0, 1'b0, 32'h0040, 32'h0, 4'b0001, g, d, h, e);
    @(negedge clk);
    tests++; if (g !== 0) begin fails++; $display("FAIL zero_stall_gnt_cycle: got %0d want 0", g); end
    tests++; if (d !== 3) begin fails++; $display("FAIL zero_stall_done_cycle: got %0d want 3", d); end
    tests++; if (rdata !== 32'h5A5A0001) begin fails++; $display("FAIL zero_stall_rdata: got %h want 5a5a0001", rdata); end
  endtask

  task automatic test_reset_mid_access();
    int g, nd; logic got_gnt;
    stall_len = 5; mem_read_data = 32'h77777777;
    got_gnt = 0; nd = 0;
    @(negedge clk);
    r0_req = 1; r0_write = 0; r0_addr = 32'h5004; r0_sign_mask = 4'b0011;
    for (int c = 0; c < 20 && !got_gnt; c++) begin
      @(negedge clk);
      if (r0_gnt) got_gnt = 1;
    end
    r0_req = 0;
    tests++; if (!got_gnt) begin fails++; $display("FAIL rstmid_gnt: got no grant want r0_gnt"); end
    repeat (2) @(negedge clk);
    tests++; if (mem_addr !== 32'h5004) begin fails++; $display("FAIL rstmid_addr_before: got %h want 00005004", mem_addr); end
    rst = 1; #1;
    tests++; if (mem_memread !== 0 || mem_memwrite !== 0) begin fails++; $display("FAIL rstmid_strobe: rd=%b wr=%b want 0", mem_memread, mem_memwrite); end
    tests++; if (r0_done !== 0 || r1_done !== 0) begin fails++; $display("FAIL rstmid_done: got %b%b want 00", r1_done, r0_done); end
    tests++; if (mem_addr !== 0 || rdata !== 0) begin fails++; $display("FAIL rstmid_async_clear: addr=%h rdata=%h want 0", mem_addr, rdata); end
    repeat (2) @(negedge clk);
    rst = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (r0_done || r1_done || r0_gnt || r1_gnt) nd++;
    end
    tests++; if (nd !== 0) begin fails++; $display("FAIL rstmid_no_activity: %0d cycles with gnt/done want 0", nd); end
    stall_len = 0; mem_read_data = 32'h0BADC0DE;
    r0_req = 1; r0_write = 0; r0_addr = 32'h6000; r0_sign_mask = 4'b1111;
    r1_req = 1; r1_write = 0; r1_addr = 32'h7000; r1_sign_mask = 4'b1111;
    @(negedge clk);
    r0_req = 0; r1_req = 0;
    tests++; if (r0_gnt !== 1 || r1_gnt !== 0) begin fails++; $display("FAIL post_rst_priority: gnt1gnt0=%b%b want 01", r1_gnt, r0_gnt); end
    g = -1;
    for (int c = 1; c < 20 && g < 0; c++) begin
      @(negedge clk);
      if (r0_done) g = c;
    end
    @(negedge clk);
    tests++; if (g !== 3) begin fails++; $display("FAIL post_rst_done_cycle: got %0d want 3", g); end
    tests++; if (rdata !== 32'h0BADC0DE) begin fails++; $display("FAIL post_rst_rdata: got %h want 0badc0de", rdata); end
  endtask

`ifdef DMEM_ARB_TIMEOUT_EN
  task automatic test_timeout();
    int g, d, h; logic e;
    stall_len = 0; stall_stuck = 1'b1; mem_read_data = 32'h12345678;
    do_access(0, 1'b0, 32'h8000, 32'h0, 4'b1111, g, d, h, e);
    stall_stuck = 1'b0;
    @(negedge clk);
    tests++; if (d !== 33) begin fails++; $display("FAIL timeout_done_cycle: got %0d want 33", d); end
    tests++; if (e !== 1'b1) begin fails++; $display("FAIL timeout_err: got %b want 1", e); end
    tests++; if (rdata !== 32'hDEADBEEF) begin fails++; $display("FAIL timeout_rdata: got %h want deadbeef", rdata); end
    do_access(0, 1'b0, 32'h8004, 32'h0, 4'b1111, g, d, h, e);
    tests++; if (d !== 3 || e !== 1'b0) begin fails++; $display("FAIL timeout_recover: done=%0d err=%b want 3/0", d, e); end
  endtask
`endif

  initial begin
    rst = 1;
    r0_req = 0; r0_write = 0; r0_addr = 0; r0_wdata = 0; r0_sign_mask = 0;
    r1_req = 0; r1_write = 0; r1_addr = 0; r1_wdata = 0; r1_sign_mask = 0;
    mem_read_data = 0;
    repeat (3) @(negedge clk);
    test_reset();
    rst = 0;
    @(negedge clk);
    test_r0_load();
    test_r1_store();
    test_round_robin();
    test_zero_stall();
    test_reset_mid_access();
`ifdef DMEM_ARB_TIMEOUT_EN
    test_timeout();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-requester arbiter and sequencer in front of the data memory (`data_mem`).
- Requester 0 is the core load/store path; requester 1 is the debug/DMA port.
- Serialises accesses and issues the one-cycle memread/memwrite strobe. Holds address, data and mask stable while the memory's clk_stall is high, then returns the read data with a done pulse.
- Round-robin fairness when both requesters are active.

Parameters:
- STALL_SETTLE, 1, minimum WAIT cycles before mem_clk_stall is sampled; covers the memory's one-cycle stall-assert latency.
- TIMEOUT_CYCLES, 32, WAIT-cycle limit used only when DMEM_ARB_TIMEOUT_EN is defined.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous reset, active high
- r0_req  in  1  requester 0 access request
- r0_addr  in  32  requester 0 byte address
- r0_write  in  1  1 = store, 0 = load
- r0_wdata  in  32  requester 0 store data
- r0_sign_mask  in  4  requester 0 size/sign mask, passed through unchanged
- r0_gnt  out  1  one-cycle pulse: request 0 accepted
- r0_done  out  1  one-cycle pulse: request 0 complete
- r1_req, r1_addr, r1_write, r1_wdata, r1_sign_mask, r1_gnt, r1_done: same as requester 0, for requester 1
- rdata  out  32  load data of the most recent completed read
- err  out  1  one-cycle pulse with done on timeout; constant 0 without the macro
- mem_addr  out  32  to data_mem addr
- mem_write_data  out  32  to data_mem write_data
- mem_memwrite  out  1  to data_mem memwrite
- mem_memread  out  1  to data_mem memread
- mem_sign_mask  out  4  to data_mem sign_mask
- mem_read_data  in  32  from data_mem read_data
- mem_clk_stall  in  1  from data_mem clk_stall

Behaviour:
- Reset values: all outputs 0, state IDLE, wait counter 0, last_owner=1 so requester 0 wins the first tie.
- Reset is asynchronous. Asserting rst mid-access drops mem_memread/mem_memwrite immediately and abandons the access; no done pulse is issued.
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - Only r0_req: grant 0. Only r1_req: grant 1.
  - Both: grant the requester that is not last_owner.
  - On grant: latch that requester's addr/wdata/sign_mask/write into mem_* registers, pulse rN_gnt, record owner, go to ISSUE.
  - No request: stay in IDLE.
- ISSUE: exactly one cycle. mem_memread = !write, mem_memwrite = write. Clear wait counter, go to WAIT.
- WAIT:
  - Strobes low; mem_addr/mem_write_data/mem_sign_mask held stable.
  - Counter increments each cycle, saturating.
  - Leave when counter >= STALL_SETTLE and mem_clk_stall == 0.
  - On a load, capture mem_read_data into rdata on that edge. Go to DONE.
- DONE: one cycle. Pulse rN_done for the owner, set last_owner = owner, go to IDLE.
- Stores leave rdata unchanged.
- Latency with zero memory stall: gnt in cycle 0, strobe in cycle 1, WAIT for STALL_SETTLE cycles, done in cycle 2+STALL_SETTLE. Minimum 4 cycles request-to-done at the default.
- Requesters may drop req after gnt. Fields are latched at grant, so later changes to inputs have no effect on the access in flight.
- A req still high after done is a new request and is arbitrated in IDLE on the following cycle, so a waiting peer wins.
- Requests arriving outside IDLE are not seen until IDLE. No queueing beyond the level-sensitive req.
- gnt and done are never asserted to both requesters in the same cycle.

Optional Feature:
- Macro: DMEM_ARB_TIMEOUT_EN.
- Defined: in WAIT, if the counter reaches TIMEOUT_CYCLES while mem_clk_stall is still 1, go to DONE with err=1 alongside rN_done. rdata is set to 32'hDEADBEEF for a load and unchanged for a store.
- Undefined: WAIT has no bound and err is tied 0.

Test Plan:
- Reset then r0 load: r0_addr=32'h1001, sign_mask=4'b0010, memory stalls 3 cycles, mem_read_data=32'h00001748 → single mem_memread pulse; mem_addr held at 32'h1001 throughout; r0_done pulses; rdata=32'h00001748.
- r1 store: addr=32'h2000, wdata=32'hCAFEF00D → single mem_memwrite pulse; mem_write_data stable until done; rdata unchanged.
- Both requesters held high for 4 accesses → grant order 0,1,0,1; no cycle with both gnt or both done.
- rst asserted in the second WAIT cycle of a load → mem_memread/mem_memwrite and all done lines 0 immediately; after release, next access starts cleanly from IDLE with r0 priority.
- Zero-stall memory, r0 load → r0_gnt at cycle 0, r0_done at cycle 3 (STALL_SETTLE=1).
- With DMEM_ARB_TIMEOUT_EN and mem_clk_stall stuck at 1, r0 load → err and r0_done pulse together 32 WAIT cycles in; rdata=32'hDEADBEEF; arbiter returns to IDLE.
